// File: rtl/harmonic_mixer_if.sv
// Bundle between the harmonic mixer and its environment: frame control, upstream position handshake, sine ROM port, mixed output.
// No storage; timing is set entirely by the mixer (ROM data expected one clock after lut_addr).
// Upstream back-pressure: the mixer waits on sample_ready and acknowledges each position with next_sample.
interface harmonic_mixer_if #(
  parameter int LUT_ADDR_W = 11
);
  logic                  sample_clock;
  logic [7:0]            harmonic_count;
  logic [7:0]            decay;
  logic                  sample_ready;
  logic [15:0]           sample_position;
  logic                  next_sample;
  logic [7:0]            harmonic;
  logic [LUT_ADDR_W-1:0] lut_addr;
  logic signed [15:0]    lut_data;
  logic signed [23:0]    mix_out;
  logic                  mix_valid;
  logic                  busy;
  logic                  overrun;

  // Mixer side.
  modport master (
    input  sample_clock, harmonic_count, decay, sample_ready, sample_position, lut_data,
    output next_sample, harmonic, lut_addr, mix_out, mix_valid, busy, overrun
  );

  // Environment side: frame tick source, position generator, sine ROM and output sink.
  modport slave (
    output sample_clock, harmonic_count, decay, sample_ready, sample_position, lut_data,
    input  next_sample, harmonic, lut_addr, mix_out, mix_valid, busy, overrun
  );
endinterface

// File: rtl/harmonic_mixer.sv
// Sums N decaying sine harmonics per sample tick into one signed 24-bit output sample.
// Latency: 4 cycles per harmonic once its position is ready, plus 2 cycles of frame overhead.
// Back-pressure: holds in WAIT_POS until sample_ready; sample ticks while busy are dropped and flagged.
module harmonic_mixer #(
  parameter int HARMONIC_MAX = 64,
  parameter int LUT_ADDR_W   = 11
) (
  input logic              clock,
  input logic              reset,
  harmonic_mixer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_POS = 3'd1,
    LOOKUP   = 3'd2,
    MAC      = 3'd3,
    ADVANCE  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [8:0] N_MAX = 9'(HARMONIC_MAX);

  state_t                 state;
  state_t                 state_nx;
  logic [7:0]             harm;
  logic [8:0]             n_lim;
  logic [8:0]             n_start;
  logic [7:0]             decay_q;
  logic [7:0]             amp;
  logic [7:0]             amp_next;
  logic signed [23:0]     acc;
  logic [LUT_ADDR_W-1:0]  addr;
  logic signed [23:0]     mix;
  logic                   mix_vld;
  logic                   last_harm;
  logic signed [24:0]     lut_ext;
  logic signed [24:0]     amp_ext;
  logic signed [24:0]     prod;
  logic signed [23:0]     term;

  // Product of signed ROM sample and unsigned amplitude; |product| < 2^23 so 25 bits never wrap.
  assign lut_ext   = $signed({{9{bus.lut_data[15]}}, bus.lut_data});
  assign amp_ext   = $signed({17'd0, amp});
  assign prod      = lut_ext * amp_ext;
  assign term      = 24'(prod >>> 8);
  assign amp_next  = 8'(({8'd0, amp} * {8'd0, decay_q}) >> 8);
  assign last_harm = ({1'b0, harm} == (n_lim - 9'd1));

  assign bus.harmonic  = harm;
  assign bus.lut_addr  = addr;
  assign bus.mix_out   = mix;
  assign bus.mix_valid = mix_vld;

  // Frame length: a zero request still sums one harmonic, and never more than HARMONIC_MAX.
  always_comb begin
    n_start = {1'b0, bus.harmonic_count};
    if (n_start == 9'd0) n_start = 9'd1;
    if (n_start > N_MAX) n_start = N_MAX;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and state-decoded outputs; a tick outside IDLE only raises overrun.
  always_comb begin
    state_nx        = state;
    bus.next_sample = 1'b0;
    bus.busy        = (state != IDLE);
    bus.overrun     = bus.sample_clock && (state != IDLE);
    case (state)
      IDLE:     if (bus.sample_clock) state_nx = WAIT_POS;
      WAIT_POS: if (bus.sample_ready) state_nx = LOOKUP;
      LOOKUP:   state_nx = MAC;
      MAC:      state_nx = ADVANCE;
      ADVANCE: begin
        bus.next_sample = 1'b1;
        state_nx        = last_harm ? DONE : WAIT_POS;
      end
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Datapath: frame setup, ROM address capture, accumulate, amplitude decay, output load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      harm    <= 8'd0;
      n_lim   <= 9'd0;
      decay_q <= 8'd0;
      amp     <= 8'd0;
      acc     <= 24'sd0;
      addr    <= '0;
      mix     <= 24'sd0;
      mix_vld <= 1'b0;
    end else begin
      mix_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sample_clock) begin
            acc     <= 24'sd0;
            amp     <= 8'hFF;
            n_lim   <= n_start;
            decay_q <= bus.decay;
            harm    <= 8'd0;
          end
        end
        WAIT_POS: begin
          if (bus.sample_ready) addr <= LUT_ADDR_W'(bus.sample_position >> (16 - LUT_ADDR_W));
        end
        MAC: acc <= acc + term;
        ADVANCE: begin
          if (last_harm) begin
            harm <= 8'd0;
          end else begin
            harm <= harm + 8'd1;
            amp  <= amp_next;
          end
        end
        DONE: begin
          mix     <= acc;
          mix_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_harmonic_mixer.sv
// Directed frame sequence with random positions/decays, checked against an arithmetic reference model.
// Frame latency expected as 4 cycles per harmonic plus 2, plus any injected upstream stall.
// Upstream stalls are injected at harmonic 2 by withholding sample_ready.
module tb_harmonic_mixer;
  localparam int LAW        = 11;
  localparam int HMAX       = 64;
  localparam int STALL_HARM = 2;
  localparam int ADDR_DIV   = 1 << (16 - LAW);

  logic clock = 1'b0;
  logic reset;

  harmonic_mixer_if #(.LUT_ADDR_W(LAW)) bus ();

  harmonic_mixer #(.HARMONIC_MAX(HMAX), .LUT_ADDR_W(LAW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic signed [15:0] rom     [0:2047];
  logic [15:0]        pos_tab [0:255];

  int ns_harm [$];
  int ns_addr [$];
  int mv_count  = 0;
  int mv_cyc    = 0;
  int ov_count  = 0;
  int stall_len = 0;
  int stall_cnt = 0;

  // Synchronous sine ROM: data one clock after the address.
  always @(posedge clock) bus.lut_data <= rom[bus.lut_addr];

  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor, sampled just after the falling edge.
  always @(negedge clock) begin
    #1;
    if (bus.next_sample === 1'b1) begin
      ns_harm.push_back(int'(bus.harmonic));
      ns_addr.push_back(int'(bus.lut_addr));
    end
    if (bus.mix_valid === 1'b1) begin
      mv_count++;
      mv_cyc = cyc;
    end
    if (bus.overrun === 1'b1) ov_count++;
  end

  // Upstream position generator: position per harmonic from pos_tab, optional stall at harmonic 2.
  always @(negedge clock) begin
    bus.sample_position = pos_tab[bus.harmonic];
    if (bus.busy !== 1'b1) begin
      stall_cnt        = 0;
      bus.sample_ready = 1'b1;
    end else if (int'(bus.harmonic) == STALL_HARM && stall_cnt < stall_len) begin
      stall_cnt++;
      bus.sample_ready = 1'b0;
    end else begin
      bus.sample_ready = 1'b1;
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int fdiv256(input int p);
    if (p >= 0) return p / 256;
    return -((-p + 255) / 256);
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_harmonic"},    bus.harmonic,          0);
    check({tag, "_lut_addr"},    bus.lut_addr,          0);
    check({tag, "_mix_out"},     $signed(bus.mix_out),  0);
    check({tag, "_next_sample"}, bus.next_sample,       0);
    check({tag, "_mix_valid"},   bus.mix_valid,         0);
    check({tag, "_busy"},        bus.busy,              0);
    check({tag, "_overrun"},     bus.overrun,           0);
  endtask

  // One full frame: model, stimulus, bounded wait for mix_valid, then sequencing/result checks.
  task automatic run_frame(input int hc, input int dec, input int stall_i, input int ovr_at, input bit rand_pos);
    int n, amp, exp_sum, start, budget, nb, mb, ob, lat, rel, held;
    n = (hc == 0) ? 1 : hc;
    if (n > HMAX) n = HMAX;
    if (rand_pos) for (int i = 0; i < 256; i++) pos_tab[i] = 16'($urandom);
    stall_len = stall_i;
    amp     = 255;
    exp_sum = 0;
    for (int i = 0; i < n; i++) begin
      exp_sum += fdiv256(int'(rom[int'(pos_tab[i]) / ADDR_DIV]) * amp);
      amp = (amp * dec) / 256;
    end
    lat = 4 * n + 2 + ((n > STALL_HARM) ? stall_i : 0);
    nb  = ns_harm.size();
    mb  = mv_count;
    ob  = ov_count;
    @(negedge clock);
    bus.harmonic_count = 8'(hc);
    bus.decay          = 8'(dec);
    bus.sample_clock   = 1'b1;
    start              = cyc;
    budget             = 0;
    while (mv_count == mb && budget < 3000) begin
      @(negedge clock);
      budget++;
      rel = cyc - start;
      bus.sample_clock = (ovr_at > 0 && rel == ovr_at) ? 1'b1 : 1'b0;
      #2;
      if (stall_i > 0 && rel >= 1 + 4 * STALL_HARM && rel < 1 + 4 * STALL_HARM + stall_i) begin
        check("stall_next_sample", bus.next_sample, 0);
        check("stall_lut_addr", bus.lut_addr, int'(pos_tab[STALL_HARM - 1]) / ADDR_DIV);
      end
    end
    bus.sample_clock = 1'b0;
    check("mix_valid_seen", mv_count - mb, 1);
    check("frame_latency", mv_cyc - start, lat);
    check("mix_out", $signed(bus.mix_out), exp_sum);
    check("next_sample_count", ns_harm.size() - nb, n);
    for (int i = 0; i < n && nb + i < ns_harm.size(); i++) begin
      check("ns_harmonic", ns_harm[nb + i], i);
      check("ns_lut_addr", ns_addr[nb + i], int'(pos_tab[i]) / ADDR_DIV);
    end
    check("overrun_count", ov_count - ob, (ovr_at > 0) ? 1 : 0);
    held = 0;
    repeat (6) begin
      @(negedge clock);
      #2;
      if (bus.busy === 1'b1) held++;
    end
    check("idle_after_frame", held, 0);
    check("single_mix_valid", mv_count - mb, 1);
    check("mix_out_hold", $signed(bus.mix_out), exp_sum);
  endtask

  initial begin
    int reached, mb;
    reset              = 1'b0;
    bus.sample_clock   = 1'b0;
    bus.harmonic_count = 8'd0;
    bus.decay          = 8'd0;
    for (int i = 0; i < 2048; i++) begin
      real x;
      x = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 2048.0);
      rom[i] = 16'($rtoi((x >= 0.0) ? x + 0.5 : x - 0.5));
    end
    for (int i = 0; i < 256; i++) pos_tab[i] = 16'd0;

    repeat (2) @(negedge clock);
    #1;
    check_outputs_zero("reset");
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Full-scale single harmonic at a quarter turn.
    pos_tab[0] = 16'h4000;
    run_frame(1, 0, 0, 0, 1'b0);
    check("fullscale_mix", $signed(bus.mix_out), 32639);
    check("fullscale_addr", (ns_addr.size() > 0) ? ns_addr[ns_addr.size() - 1] : -1, 512);

    // Four harmonics, halving decay, no stall.
    run_frame(4, 128, 0, 0, 1'b1);
    // Upstream withholds sample_ready for 10 cycles at harmonic 2.
    run_frame(4, int'($urandom_range(0, 255)), 10, 0, 1'b1);
    // Tick arrives mid-frame.
    run_frame(4, 128, 0, 5, 1'b1);
    // Count boundaries.
    run_frame(0, int'($urandom_range(0, 255)), 0, 0, 1'b1);
    run_frame(200, 250, 0, 0, 1'b1);
    // Random frames.
    for (int k = 0; k < 5; k++)
      run_frame(int'($urandom_range(1, 80)), int'($urandom_range(0, 255)), 0, 0, 1'b1);

    // Reset in the middle of an 8-harmonic frame.
    stall_len = 0;
    for (int i = 0; i < 256; i++) pos_tab[i] = 16'($urandom);
    @(negedge clock);
    bus.harmonic_count = 8'd8;
    bus.decay          = 8'd200;
    bus.sample_clock   = 1'b1;
    @(negedge clock);
    bus.sample_clock   = 1'b0;
    reached = 0;
    for (int t = 0; t < 200 && reached == 0; t++) begin
      @(negedge clock);
      #1;
      if (bus.harmonic === 8'd3) reached = 1;
    end
    check("reach_harmonic3", reached, 1);
    mb    = mv_count;
    reset = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    #2;
    check("abort_no_mix_valid", mv_count - mb, 0);
    check("abort_idle", bus.busy, 0);
    check("abort_harmonic", bus.harmonic, 0);
    run_frame(8, int'($urandom_range(0, 255)), 0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
